// File: rtl/pc_sequencer.sv
// Program-counter sequencer: linear instruction fetch with prioritised, nestable
// interrupts, a vector table and a hardware return-address stack.
//   state  | meaning
//   START  | first cycle after reset
//   RUN    | fetch; arbitrate interrupt > return > advance
//   VECTOR | push {addr_ins, cur_level}, jump to vector entry, pulse int_ack
//   RETURN | pop and restore context (or flag empty pop), pulse ret_ack
module pc_sequencer #(
    parameter int ADDR_WIDTH_MEM  = 16,
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int ISA_DEPTH       = 64,
    parameter int TOTAL_ISA_DEPTH = 128,
    parameter int NUM_INT         = 4,
    parameter int STACK_DEPTH     = 4,
    parameter int INS_BYTE_SHIFT  = 3,
    parameter int VEC_STRIDE_LOG2 = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_INT-1:0]                 int_req,
    output logic [NUM_INT-1:0]                 int_ack,
    input  logic [DDR_ADDR_WIDTH-1:0]          vec_base,
    input  logic                               ret_valid,
    output logic                               ret_ack,
    input  logic                               ins_inp_valid,
    input  logic                               ins_cache_rdy,
    input  logic [3:0]                         st_cur_ins_cache,
    input  logic [9:0]                         load_times,
    output logic [ADDR_WIDTH_MEM-1:0]          addr_ins,
    output logic [ADDR_WIDTH_MEM-1:0]          addr_cur_ins,
    output logic [$clog2(NUM_INT+1)-1:0]       cur_level,
    output logic                               stack_err
);

    localparam int LW  = $clog2(NUM_INT + 1);
    localparam int IW  = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SAW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] SENT_INS = 4'd3;

    typedef enum logic [1:0] {S_START, S_RUN, S_VECTOR, S_RETURN} state_t;

    state_t                    state, next_state;
    logic [NUM_INT-1:0]        req_q;
    logic [NUM_INT-1:0]        pending;
    logic [SPW-1:0]            sp;
    logic [IW-1:0]             irq_idx;
    logic [IW-1:0]             irq_sel;
    logic                      irq_found;
    logic                      eligible;
    logic                      adv_ok;
    logic [31:0]               win_end;
    logic [ADDR_WIDTH_MEM-1:0] vec_addr;
    logic [SAW-1:0]            push_idx;
    logic [SAW-1:0]            pop_idx;
    logic                      unused_vec_hi;

    logic [ADDR_WIDTH_MEM-1:0] stk_addr [STACK_DEPTH];
    logic [LW-1:0]             stk_lvl  [STACK_DEPTH];

    assign unused_vec_hi = ^vec_base[DDR_ADDR_WIDTH-1:ADDR_WIDTH_MEM];

    // Lowest pending index wins; it is only taken if it outranks the active level.
    always_comb begin
        irq_found = 1'b0;
        irq_idx   = '0;
        for (int k = NUM_INT - 1; k >= 0; k--) begin
            if (pending[k]) begin
                irq_found = 1'b1;
                irq_idx   = IW'(k);
            end
        end
    end

    assign eligible = irq_found && (LW'(irq_idx) < cur_level) && (sp < SPW'(STACK_DEPTH));

    assign win_end = ISA_DEPTH[31:0] * {22'd0, load_times};
    assign adv_ok  = ins_inp_valid && ins_cache_rdy && (st_cur_ins_cache == SENT_INS)
                     && (32'(addr_ins) < TOTAL_ISA_DEPTH[31:0])
                     && (32'(addr_ins) != win_end);

    assign vec_addr = (vec_base[ADDR_WIDTH_MEM-1:0] >> INS_BYTE_SHIFT)
                      + (ADDR_WIDTH_MEM'(irq_sel) << VEC_STRIDE_LOG2);

    assign push_idx = sp[SAW-1:0];
    assign pop_idx  = SAW'(sp - SPW'(1));

    always_ff @(posedge clk) begin
        if (!rst) state <= S_START;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_START:  next_state = S_RUN;
            S_RUN: begin
                if (eligible)       next_state = S_VECTOR;
                else if (ret_valid) next_state = S_RETURN;
            end
            S_VECTOR: next_state = S_RUN;
            S_RETURN: next_state = S_RUN;
            default:  next_state = S_START;
        endcase
    end

    always_comb begin
        int_ack = '0;
        ret_ack = 1'b0;
        case (state)
            S_VECTOR: int_ack = NUM_INT'(1) << irq_sel;
            S_RETURN: ret_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_ins     <= '0;
            addr_cur_ins <= '0;
            cur_level    <= LW'(NUM_INT);
            sp           <= '0;
            pending      <= '0;
            req_q        <= '0;
            stack_err    <= 1'b0;
            irq_sel      <= '0;
        end else begin
            req_q   <= int_req;
            // A new rising edge in the ack cycle keeps the bit set.
            pending <= (pending & ~int_ack) | (int_req & ~req_q);
            case (state)
                S_RUN: begin
                    if (eligible) begin
                        irq_sel <= irq_idx;
                    end else if (!ret_valid && adv_ok) begin
                        addr_ins     <= addr_ins + ADDR_WIDTH_MEM'(1);
                        addr_cur_ins <= addr_ins + ADDR_WIDTH_MEM'(1);
                    end
                end
                S_VECTOR: begin
                    stk_addr[push_idx] <= addr_ins;
                    stk_lvl[push_idx]  <= cur_level;
                    sp                 <= sp + SPW'(1);
                    addr_ins           <= vec_addr;
                    addr_cur_ins       <= vec_addr;
                    cur_level          <= LW'(irq_sel);
                end
                S_RETURN: begin
                    if (sp != '0) begin
                        sp           <= sp - SPW'(1);
                        addr_ins     <= stk_addr[pop_idx];
                        addr_cur_ins <= stk_addr[pop_idx];
                        cur_level    <= stk_lvl[pop_idx];
                    end else begin
                        stack_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized fetch
// and interrupt/return traffic against a queue-based reference model.
module tb_pc_sequencer;

    localparam int SD = 2;
    localparam int NI = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [2:0]  l;
    } ctx_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  int_req;
    logic [3:0]  int_ack;
    logic [27:0] vec_base;
    logic        ret_valid;
    logic        ret_ack;
    logic        ins_inp_valid;
    logic        ins_cache_rdy;
    logic [3:0]  st_cur_ins_cache;
    logic [9:0]  load_times;
    logic [15:0] addr_ins;
    logic [15:0] addr_cur_ins;
    logic [2:0]  cur_level;
    logic        stack_err;

    int checks   = 0;
    int failures = 0;

    pc_sequencer #(.STACK_DEPTH(SD)) dut (
        .clk              (clk),
        .rst              (rst),
        .int_req          (int_req),
        .int_ack          (int_ack),
        .vec_base         (vec_base),
        .ret_valid        (ret_valid),
        .ret_ack          (ret_ack),
        .ins_inp_valid    (ins_inp_valid),
        .ins_cache_rdy    (ins_cache_rdy),
        .st_cur_ins_cache (st_cur_ins_cache),
        .load_times       (load_times),
        .addr_ins         (addr_ins),
        .addr_cur_ins     (addr_cur_ins),
        .cur_level        (cur_level),
        .stack_err        (stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit adv_rule(int a, int lt, bit v, bit r, int st);
        return v && r && (st == 3) && (a < 128) && (a != 64 * lt);
    endfunction

    function automatic logic [15:0] vec_of(logic [27:0] vb, int i);
        logic [15:0] lo;
        lo = vb[15:0];
        return 16'((lo >> 3) + 16'(i * 16));
    endfunction

    task automatic set_hs(input bit on);
        ins_inp_valid    = on;
        ins_cache_rdy    = on;
        st_cur_ins_cache = on ? 4'd3 : 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        int_req    = '0;
        ret_valid  = 1'b0;
        load_times = '0;
        set_hs(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_int(input logic [3:0] m);
        @(negedge clk);
        int_req = m;
        @(negedge clk);
        int_req = '0;
    endtask

    task automatic wait_ack(output logic [3:0] seen, output bit got, output bit ret_seen);
        got = 1'b0;
        seen = '0;
        ret_seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ret_ack) ret_seen = 1'b1;
            if (int_ack != 4'd0) begin
                seen = int_ack;
                got  = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ret(output bit got);
        got = 1'b0;
        ret_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ret_ack) begin
                got = 1'b1;
                break;
            end
        end
        ret_valid = 1'b0;
    endtask

    task automatic quiet(input int n, output int bad);
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (int_ack != 4'd0 || ret_ack) bad++;
        end
    endtask

    task automatic goto10();
        do_reset();
        load_times = 10'd1;
        set_hs(1'b1);
        repeat (10) @(negedge clk);
        set_hs(1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        int_req = '0;
        ret_valid = 1'b0;
        load_times = '0;
        vec_base = 28'h400;
        set_hs(1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({addr_ins, addr_cur_ins} !== 32'h0) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 00000000", {addr_ins, addr_cur_ins});
        end
        checks++;
        if (cur_level !== 3'd4) begin
            failures++;
            $display("FAIL reset_level: got %0d expected 4", cur_level);
        end
        checks++;
        if ({int_ack, ret_ack, stack_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000000", {int_ack, ret_ack, stack_err});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_linear();
        int m;
        bit cond;
        do_reset();
        set_hs(1'b1);
        m = 0;
        for (int phase = 1; phase <= 2; phase++) begin
            load_times = 10'(phase);
            for (int c = 0; c < 80; c++) begin
                cond = adv_rule(m, phase, 1'b1, 1'b1, 3);
                @(negedge clk);
                if (cond) m++;
                checks++;
                if (addr_ins !== 16'(m) || addr_cur_ins !== 16'(m)) begin
                    failures++;
                    $display("FAIL linear_addr: got %0d/%0d expected %0d", addr_ins, addr_cur_ins, m);
                end
            end
            checks++;
            if (addr_ins !== 16'(64 * phase)) begin
                failures++;
                $display("FAIL linear_hold: got %0d expected %0d", addr_ins, 64 * phase);
            end
        end
        set_hs(1'b0);
    endtask

    task automatic test_random_fetch();
        int m, lt, st;
        bit v, r, cond;
        do_reset();
        m = 0;
        lt = 1;
        for (int c = 0; c < 300; c++) begin
            if (c % 60 == 0) lt = $urandom_range(0, 3);
            v = ($urandom % 4) != 0;
            r = ($urandom % 4) != 0;
            st = (($urandom % 4) == 0) ? int'($urandom_range(0, 15)) : 3;
            load_times       = 10'(lt);
            ins_inp_valid    = v;
            ins_cache_rdy    = r;
            st_cur_ins_cache = 4'(st);
            cond = adv_rule(m, lt, v, r, st);
            @(negedge clk);
            if (cond) m++;
            checks++;
            if (addr_ins !== 16'(m) || addr_cur_ins !== 16'(m)) begin
                failures++;
                $display("FAIL rand_fetch: got %0d/%0d expected %0d", addr_ins, addr_cur_ins, m);
            end
        end
        set_hs(1'b0);
    endtask

    task automatic test_single_irq();
        logic [3:0] seen;
        bit got, rs;
        goto10();
        vec_base = 28'h400;
        checks++;
        if (addr_ins !== 16'd10) begin
            failures++;
            $display("FAIL single_start: got %0d expected 10", addr_ins);
        end
        pulse_int(4'b0100);
        wait_ack(seen, got, rs);
        checks++;
        if (!got || seen !== 4'b0100) begin
            failures++;
            $display("FAIL single_ack: got %b (seen=%0d) expected 0100", seen, got);
        end
        @(negedge clk);
        checks++;
        if ({int_ack, addr_ins, addr_cur_ins, cur_level} !== {4'b0, 16'h00A0, 16'h00A0, 3'd2}) begin
            failures++;
            $display("FAIL single_vector: got ack=%b addr=%h cur=%h lvl=%0d expected 0000 00a0 00a0 2",
                     int_ack, addr_ins, addr_cur_ins, cur_level);
        end
        wait_ret(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL single_ret_ack: got none expected pulse");
        end
        @(negedge clk);
        checks++;
        if ({ret_ack, addr_ins, addr_cur_ins, cur_level} !== {1'b0, 16'd10, 16'd10, 3'd4}) begin
            failures++;
            $display("FAIL single_restore: got ack=%b addr=%0d cur=%0d lvl=%0d expected 0 10 10 4",
                     ret_ack, addr_ins, addr_cur_ins, cur_level);
        end
    endtask

    task automatic test_nesting();
        logic [3:0] seen;
        bit got, rs;
        int bad;
        pulse_int(4'b0100);
        wait_ack(seen, got, rs);
        @(negedge clk);
        pulse_int(4'b1001);
        wait_ack(seen, got, rs);
        checks++;
        if (!got || seen !== 4'b0001) begin
            failures++;
            $display("FAIL nest_ack0: got %b expected 0001", seen);
        end
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'h0080, 3'd0}) begin
            failures++;
            $display("FAIL nest_vec0: got addr=%h lvl=%0d expected 0080 0", addr_ins, cur_level);
        end
        quiet(4, bad);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL nest_int3_held: got %0d ack cycles expected 0", bad);
        end
        wait_ret(got);
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'h00A0, 3'd2}) begin
            failures++;
            $display("FAIL nest_ret1: got addr=%h lvl=%0d expected 00a0 2", addr_ins, cur_level);
        end
        wait_ret(got);
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'd10, 3'd4}) begin
            failures++;
            $display("FAIL nest_ret2: got addr=%0d lvl=%0d expected 10 4", addr_ins, cur_level);
        end
        wait_ack(seen, got, rs);
        checks++;
        if (!got || seen !== 4'b1000) begin
            failures++;
            $display("FAIL nest_delayed3: got %b expected 1000", seen);
        end
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'h00B0, 3'd3}) begin
            failures++;
            $display("FAIL nest_vec3: got addr=%h lvl=%0d expected 00b0 3", addr_ins, cur_level);
        end
        wait_ret(got);
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'd10, 3'd4}) begin
            failures++;
            $display("FAIL nest_final: got addr=%0d lvl=%0d expected 10 4", addr_ins, cur_level);
        end
    endtask

    task automatic test_stack_full();
        logic [3:0] seen;
        bit got, rs;
        int bad;
        pulse_int(4'b1000);
        wait_ack(seen, got, rs);
        @(negedge clk);
        pulse_int(4'b0010);
        wait_ack(seen, got, rs);
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'h0090, 3'd1}) begin
            failures++;
            $display("FAIL full_vec1: got addr=%h lvl=%0d expected 0090 1", addr_ins, cur_level);
        end
        pulse_int(4'b0001);
        quiet(6, bad);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL full_blocked: got %0d ack cycles expected 0", bad);
        end
        wait_ret(got);
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'h00B0, 3'd3}) begin
            failures++;
            $display("FAIL full_ret: got addr=%h lvl=%0d expected 00b0 3", addr_ins, cur_level);
        end
        wait_ack(seen, got, rs);
        checks++;
        if (!got || seen !== 4'b0001) begin
            failures++;
            $display("FAIL full_late_ack: got %b expected 0001", seen);
        end
        @(negedge clk);
        wait_ret(got);
        @(negedge clk);
        wait_ret(got);
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level, stack_err} !== {16'd10, 3'd4, 1'b0}) begin
            failures++;
            $display("FAIL full_unwind: got addr=%0d lvl=%0d err=%b expected 10 4 0", addr_ins, cur_level, stack_err);
        end
    endtask

    task automatic test_empty_ret();
        bit got;
        wait_ret(got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL empty_ret_ack: got none expected pulse");
        end
        @(negedge clk);
        checks++;
        if ({stack_err, addr_ins, cur_level} !== {1'b1, 16'd10, 3'd4}) begin
            failures++;
            $display("FAIL empty_ret: got err=%b addr=%0d lvl=%0d expected 1 10 4", stack_err, addr_ins, cur_level);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] seen;
        bit got, rs;
        pulse_int(4'b0010);
        ret_valid = 1'b1;
        wait_ack(seen, got, rs);
        checks++;
        if (!got || seen !== 4'b0010 || rs) begin
            failures++;
            $display("FAIL simul_irq_first: got ack=%b ret_seen=%b expected 0010 0", seen, rs);
        end
        @(negedge clk);
        checks++;
        if ({addr_ins, cur_level} !== {16'h0090, 3'd1}) begin
            failures++;
            $display("FAIL simul_vec: got addr=%h lvl=%0d expected 0090 1", addr_ins, cur_level);
        end
        wait_ret(got);
        @(negedge clk);
        checks++;
        if (!got || {addr_ins, cur_level, stack_err} !== {16'd10, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL simul_ret: got ack=%b addr=%0d lvl=%0d err=%b expected 1 10 4 1",
                     got, addr_ins, cur_level, stack_err);
        end
    endtask

    task automatic test_random_irq();
        logic [27:0] vb;
        logic [15:0] ma;
        logic [2:0]  ml;
        logic        merr;
        logic [3:0]  pend;
        ctx_t        stk[$];
        ctx_t        c;
        logic [3:0]  seen;
        bit got, rs;
        int j, lo, bad;
        do_reset();
        vb = 28'($urandom);
        vec_base = vb;
        ma = '0;
        ml = 3'd4;
        merr = 1'b0;
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                j = $urandom_range(0, 3);
                pulse_int(4'(1 << j));
                pend[j] = 1'b1;
            end else begin
                wait_ret(got);
                @(negedge clk);
                if (stk.size() > 0) begin
                    c = stk.pop_back();
                    ma = c.a;
                    ml = c.l;
                end else begin
                    merr = 1'b1;
                end
                checks++;
                if (!got || {addr_ins, cur_level, stack_err} !== {ma, ml, merr}) begin
                    failures++;
                    $display("FAIL rand_ret: got ack=%b addr=%h lvl=%0d err=%b expected 1 %h %0d %b",
                             got, addr_ins, cur_level, stack_err, ma, ml, merr);
                end
            end
            for (int s = 0; s < NI; s++) begin
                lo = -1;
                for (int k = NI - 1; k >= 0; k--) if (pend[k]) lo = k;
                if (lo < 0 || lo >= int'(ml) || stk.size() >= SD) break;
                wait_ack(seen, got, rs);
                checks++;
                if (!got || seen !== 4'(1 << lo)) begin
                    failures++;
                    $display("FAIL rand_ack: got %b expected %b", seen, 4'(1 << lo));
                end
                @(negedge clk);
                c.a = ma;
                c.l = ml;
                stk.push_back(c);
                ma = vec_of(vb, lo);
                ml = 3'(lo);
                pend[lo] = 1'b0;
                checks++;
                if ({addr_ins, addr_cur_ins, cur_level} !== {ma, ma, ml}) begin
                    failures++;
                    $display("FAIL rand_vec: got addr=%h cur=%h lvl=%0d expected %h %h %0d",
                             addr_ins, addr_cur_ins, cur_level, ma, ma, ml);
                end
            end
            quiet(3, bad);
            checks++;
            if (bad !== 0) begin
                failures++;
                $display("FAIL rand_quiet: got %0d unexpected pulses expected 0", bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seen;
        bit got, rs;
        int bad;
        do_reset();
        vec_base = 28'h400;
        pulse_int(4'b0100);
        wait_ack(seen, got, rs);
        @(negedge clk);
        pulse_int(4'b0001);
        wait_ack(seen, got, rs);
        @(negedge clk);
        pulse_int(4'b1000);
        checks++;
        if ({addr_ins, cur_level} !== {16'h0080, 3'd0}) begin
            failures++;
            $display("FAIL mid_nested: got addr=%h lvl=%0d expected 0080 0", addr_ins, cur_level);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({addr_ins, addr_cur_ins, cur_level, int_ack, ret_ack, stack_err} !==
            {16'd0, 16'd0, 3'd4, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: got addr=%h cur=%h lvl=%0d ack=%b rack=%b err=%b expected 0 0 4 0 0 0",
                     addr_ins, addr_cur_ins, cur_level, int_ack, ret_ack, stack_err);
        end
        rst = 1'b1;
        @(negedge clk);
        quiet(6, bad);
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL mid_pending_dropped: got %0d pulses expected 0", bad);
        end
        wait_ret(got);
        @(negedge clk);
        checks++;
        if ({stack_err, addr_ins, cur_level} !== {1'b1, 16'd0, 3'd4}) begin
            failures++;
            $display("FAIL mid_stack_dropped: got err=%b addr=%h lvl=%0d expected 1 0000 4", stack_err, addr_ins, cur_level);
        end
    endtask

    initial begin
        rst = 1'b0;
        int_req = '0;
        ret_valid = 1'b0;
        load_times = '0;
        vec_base = 28'h400;
        set_hs(1'b0);
        test_reset();
        test_linear();
        test_random_fetch();
        test_single_irq();
        test_nesting();
        test_stack_full();
        test_empty_ret();
        test_simultaneous();
        test_random_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
